// File: rtl/tuser_in_splitter_if.sv
// Stream bundle for tuser_in_splitter: AXIS ingress (tin_a*), data-only egress (tin_b*)
// and the per-packet tuple stream (tin_valid/tin_ready/tin_data).
interface tuser_in_splitter_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic                tin_avalid;
    logic                tin_aready;
    logic [DATA_W-1:0]   tin_adata;
    logic [DATA_W/8-1:0] tin_akeep;
    logic                tin_atlast;
    logic [USER_W-1:0]   tin_atuser;

    logic                tin_bvalid;
    logic                tin_bready;
    logic [DATA_W-1:0]   tin_bdata;
    logic [DATA_W/8-1:0] tin_bkeep;
    logic                tin_btlast;

    logic                tin_valid;
    logic                tin_ready;
    logic [USER_W-1:0]   tin_data;

    // Splitter side: sinks tin_a, sources tin_b and the tuple stream.
    modport slave (
        input  tin_avalid, tin_adata, tin_akeep, tin_atlast, tin_atuser,
        output tin_aready,
        output tin_bvalid, tin_bdata, tin_bkeep, tin_btlast,
        input  tin_bready,
        output tin_valid, tin_data,
        input  tin_ready
    );

    // Environment side: sources tin_a, sinks tin_b and the tuple stream.
    modport master (
        output tin_avalid, tin_adata, tin_akeep, tin_atlast, tin_atuser,
        input  tin_aready,
        input  tin_bvalid, tin_bdata, tin_bkeep, tin_btlast,
        output tin_bready,
        input  tin_valid, tin_data,
        output tin_ready
    );
endinterface

// File: rtl/tuser_in_splitter.sv
// Splits AXIS ingress into a data-only stream and a per-packet tuple stream (first-beat tuser).
// Optional statistics counters are compiled in when TIN_STATS_EN is defined.
module tuser_in_splitter #(
    parameter int DATA_W      = 256,
    parameter int USER_W      = 128,
    parameter int TUPLE_DEPTH = 4
`ifdef TIN_STATS_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic                tin_aclk,
    input  logic                tin_arst,
    tuser_in_splitter_if.slave  bus,
    output logic [1:0]          dbg_state
`ifdef TIN_STATS_EN
    ,
    output logic [CNT_W-1:0]    stat_pkts,
    output logic [CNT_W-1:0]    stat_beats,
    output logic [CNT_W-1:0]    stat_sop_stall
`endif
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(TUPLE_DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_SOP  = 2'b00,
        ST_BODY = 2'b01
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    state_t            state_q, state_d;
    logic              rdy_en_q;
    beat_t             in_beat, out_q, skid_q;
    logic              out_vld_q, skid_vld_q;
    logic [USER_W-1:0] mem [TUPLE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              full_q;
    logic [USER_W-1:0] head_q;
    logic              at_sop, accept, pop_out, push, pop_t;

    // Unused encodings fall back to SOP so a corrupted state resynchronises on the next beat.
    assign at_sop  = (state_q != ST_BODY);
    assign accept  = bus.tin_avalid & bus.tin_aready;
    assign pop_out = out_vld_q & bus.tin_bready;
    assign push    = accept & at_sop;
    assign pop_t   = (occ_q != '0) & bus.tin_ready;
    assign rd_nxt  = rd_ptr_q + PTR_W'(1);
    assign in_beat = {bus.tin_adata, bus.tin_akeep, bus.tin_atlast};

    // rdy_en_q holds tin_aready low through reset and releases it on the first edge after.
    assign bus.tin_aready = rdy_en_q & ~skid_vld_q & ~(at_sop & full_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tin_aclk or negedge tin_arst) begin
        if (!tin_arst) state_q <= ST_SOP;
        else           state_q <= state_d;
    end

    // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BODY: if (accept && bus.tin_atlast) state_d = ST_SOP;
            default: state_d = (accept && !bus.tin_atlast) ? ST_BODY : ST_SOP;
        endcase
    end

    assign dbg_state = state_q;

    // Output register plus skid entry; the skid only fills when a beat lands on a stalled output.
    always_ff @(posedge tin_aclk or negedge tin_arst) begin
        if (!tin_arst) begin
            rdy_en_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (skid_vld_q) begin
                if (pop_out) begin
                    out_q      <= skid_q;
                    skid_vld_q <= 1'b0;
                end
            end else if (accept) begin
                if (!out_vld_q || pop_out) begin
                    out_q     <= in_beat;
                    out_vld_q <= 1'b1;
                end else begin
                    skid_q     <= in_beat;
                    skid_vld_q <= 1'b1;
                end
            end else if (pop_out) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.tin_bvalid = out_vld_q;
    assign bus.tin_bdata  = out_q.data;
    assign bus.tin_bkeep  = out_q.keep;
    assign bus.tin_btlast = out_q.last;

    // NOTE: tuple storage carries no reset; occupancy and pointers alone define which entries are live.
    always_ff @(posedge tin_aclk) begin
        if (push) mem[wr_ptr_q] <= bus.tin_atuser;
    end

    assign occ_d = occ_q + OCC_W'(push) - OCC_W'(pop_t);

    // head_q mirrors mem[rd_ptr_q] one cycle ahead so tin_data comes straight from a flop.
    always_ff @(posedge tin_aclk or negedge tin_arst) begin
        if (!tin_arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            head_q   <= '0;
        end else begin
            occ_q  <= occ_d;
            full_q <= (occ_d == OCC_W'(TUPLE_DEPTH));
            if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_t) rd_ptr_q <= rd_nxt;
            if (pop_t) begin
                if (occ_q > OCC_W'(1)) head_q <= mem[rd_nxt];
                else if (push)         head_q <= bus.tin_atuser;
            end else if (push && occ_q == '0) begin
                head_q <= bus.tin_atuser;
            end
        end
    end

    assign bus.tin_valid = (occ_q != '0);
    assign bus.tin_data  = head_q;

`ifdef TIN_STATS_EN
    always_ff @(posedge tin_aclk or negedge tin_arst) begin
        if (!tin_arst) begin
            stat_pkts      <= '0;
            stat_beats     <= '0;
            stat_sop_stall <= '0;
        end else begin
            if (accept)                               stat_beats     <= stat_beats + CNT_W'(1);
            if (accept && bus.tin_atlast)             stat_pkts      <= stat_pkts + CNT_W'(1);
            if (at_sop && bus.tin_avalid && full_q)   stat_sop_stall <= stat_sop_stall + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_tuser_in_splitter.sv
// Randomised scoreboard bench for tuser_in_splitter: a negedge monitor checks every output
// against queues filled from the stimulus the bench itself issued.
module tb_tuser_in_splitter;
    localparam int DATA_W = 256;
    localparam int USER_W = 128;
    localparam int DEPTH  = 4;
    localparam int KEEP_W = DATA_W / 8;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic              l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tuser_in_splitter_if #(.DATA_W(DATA_W), .USER_W(USER_W)) bus ();
    logic [1:0] dbg_state;
`ifdef TIN_STATS_EN
    logic [31:0] stat_pkts, stat_beats, stat_sop_stall;
`endif

    tuser_in_splitter #(.DATA_W(DATA_W), .USER_W(USER_W), .TUPLE_DEPTH(DEPTH)) dut (
        .tin_aclk       (clk),
        .tin_arst       (rst_n),
        .bus            (bus),
        .dbg_state      (dbg_state)
`ifdef TIN_STATS_EN
        ,
        .stat_pkts      (stat_pkts),
        .stat_beats     (stat_beats),
        .stat_sop_stall (stat_sop_stall)
`endif
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int b_mode = 0;   // 0 always ready, 1 random, 2 toggle, 3 never
    int t_mode = 0;
    bit alive = 1'b0; // DUT has seen a clock edge since reset release
    bit in_pkt = 1'b0;
    bit cur_first = 1'b0;
    beat_t exp_q[$];
    logic [USER_W-1:0] tup_q[$];
    int m_beats = 0, m_pkts = 0, m_stall = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_d();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [USER_W-1:0] rnd_u();
        logic [USER_W-1:0] r;
        for (int i = 0; i < USER_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        alive = rst_n;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.tin_bready = 1'b0;
        bus.tin_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (b_mode)
                0: bus.tin_bready = 1'b1;
                1: bus.tin_bready = 1'($urandom_range(0, 1));
                2: bus.tin_bready = ~bus.tin_bready;
                default: bus.tin_bready = 1'b0;
            endcase
            case (t_mode)
                0: bus.tin_ready = 1'b1;
                1: bus.tin_ready = 1'($urandom_range(0, 1));
                2: bus.tin_ready = ~bus.tin_ready;
                default: bus.tin_ready = 1'b0;
            endcase
        end
    end

    // Monitor: expectations first (state after the last edge), then pops, then accepted beats.
    initial begin
        int held, tups;
        bit exp_rdy, stall_now, pb_stall, pt_stall;
        logic [DATA_W-1:0] pb_data;
        logic [USER_W-1:0] pt_data;
        beat_t e, nb;
        logic [USER_W-1:0] et;
        pb_stall = 0;
        pt_stall = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                tup_q.delete();
                in_pkt = 0;
                pb_stall = 0;
                pt_stall = 0;
                m_beats = 0; m_pkts = 0; m_stall = 0;
                check("rst_ctrl", {bus.tin_aready, bus.tin_bvalid, bus.tin_btlast, bus.tin_valid, dbg_state}, 0);
                check("rst_bdata", bus.tin_bdata, 0);
                check("rst_tdata", {bus.tin_bkeep, bus.tin_data}, 0);
`ifdef TIN_STATS_EN
                check("rst_stats", {stat_pkts, stat_beats, stat_sop_stall}, 0);
`endif
            end else begin
                held = exp_q.size();
                tups = tup_q.size();
                exp_rdy = alive && held < 2 && !(!in_pkt && tups == DEPTH);
                check("aready", bus.tin_aready, exp_rdy);
                check("bvalid", bus.tin_bvalid, held > 0);
                check("tvalid", bus.tin_valid, tups > 0);
                check("state", dbg_state, in_pkt ? 2'b01 : 2'b00);
`ifdef TIN_STATS_EN
                check("stat_beats", stat_beats, m_beats);
                check("stat_pkts", stat_pkts, m_pkts);
                check("stat_sop_stall", stat_sop_stall, m_stall);
`endif
                if (pb_stall) check("bhold", bus.tin_bdata, pb_data);
                if (pt_stall) check("thold", bus.tin_data, pt_data);
                if (bus.tin_bvalid && bus.tin_bready && held > 0) begin
                    e = exp_q.pop_front();
                    check("bdata", bus.tin_bdata, e.d);
                    check("bkeep", bus.tin_bkeep, e.k);
                    check("btlast", bus.tin_btlast, e.l);
                end
                if (bus.tin_valid && bus.tin_ready && tups > 0) begin
                    et = tup_q.pop_front();
                    check("tdata", bus.tin_data, et);
                end
                pb_stall = bus.tin_bvalid && !bus.tin_bready;
                pb_data  = bus.tin_bdata;
                pt_stall = bus.tin_valid && !bus.tin_ready;
                pt_data  = bus.tin_data;
                stall_now = !in_pkt && bus.tin_avalid && tups == DEPTH;
                if (stall_now) m_stall++;
                if (bus.tin_avalid && bus.tin_aready) begin
                    nb.d = bus.tin_adata;
                    nb.k = bus.tin_akeep;
                    nb.l = bus.tin_atlast;
                    exp_q.push_back(nb);
                    if (cur_first) tup_q.push_back(bus.tin_atuser);
                    in_pkt = !bus.tin_atlast;
                    m_beats++;
                    if (bus.tin_atlast) m_pkts++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat was taken.
    task automatic drive_beat(input logic last, input logic [USER_W-1:0] u, input bit first);
        int n;
        n = 0;
        bus.tin_avalid = 1'b1;
        bus.tin_adata  = rnd_d();
        bus.tin_akeep  = ($urandom_range(0, 7) == 0) ? '0 : KEEP_W'($urandom);
        bus.tin_atlast = last;
        bus.tin_atuser = u;
        cur_first      = first;
        forever begin
            @(negedge clk);
            if (bus.tin_aready) break;
            n++;
            if (n > 300) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.tin_avalid = 1'b0;
    endtask

    task automatic send_pkt(input int nb, input logic [USER_W-1:0] u, input int gap_max);
        for (int i = 0; i < nb; i++) begin
            drive_beat(i == nb - 1, (i == 0) ? u : rnd_u(), i == 0);
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tup_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", exp_q.size() + tup_q.size(), 0);
    endtask

    initial begin
        int t0;
        logic [USER_W-1:0] u0;
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        logic [USER_W-1:0] u0, ur;
        bus.tin_avalid = 1'b0;
        bus.tin_adata  = '0;
        bus.tin_akeep  = '0;
        bus.tin_atlast = 1'b0;
        bus.tin_atuser = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back 4-beat packets at full rate: 12 beats in 12 cycles.
        t0 = cyc;
        for (int p = 0; p < 3; p++) send_pkt(4, rnd_u(), 0);
        check("b2b_cycles", cyc - t0, 12);
        drain();

        // Single-beat packets.
        for (int p = 0; p < 8; p++) send_pkt(1, rnd_u(), 0);
        drain();

        // Tuple consumer stalled: the 5th SOP must wait, the 4th packet must finish.
        t_mode = 3;
        u0 = rnd_u();
        fork
            begin
                send_pkt(2, u0, 0);
                for (int p = 1; p < 6; p++) send_pkt(2, rnd_u(), 0);
            end
            begin
                repeat (30) @(posedge clk);
                @(negedge clk);
                check("full_aready", bus.tin_aready, 0);
                check("full_state", dbg_state, 2'b00);
                check("full_head", bus.tin_data, u0);
                t_mode = 0;
            end
        join
        drain();

        // Output stalled every other cycle during a 5-beat packet.
        b_mode = 2;
        send_pkt(5, rnd_u(), 0);
        b_mode = 0;
        drain();

        // Reset on beat 2 of 4; the next beat after release starts a fresh packet.
        drive_beat(1'b0, rnd_u(), 1'b1);
        drive_beat(1'b0, rnd_u(), 1'b0);
        b_mode = 3;
        #2 rst_n = 1'b0;
        #1;
        check("rst_now_ctrl", {bus.tin_aready, bus.tin_bvalid, bus.tin_valid, dbg_state}, 0);
        check("rst_now_data", {bus.tin_bkeep, bus.tin_data}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        b_mode = 0;
        @(posedge clk);
        #1;
        ur = rnd_u();
        send_pkt(3, ur, 0);
        @(negedge clk);
        check("post_rst_tuple", bus.tin_data, ur);
        @(posedge clk);
        #1;
        drain();

        // Random traffic with random backpressure on both outputs.
        b_mode = 1;
        t_mode = 1;
        for (int p = 0; p < 60; p++) send_pkt($urandom_range(1, 6), rnd_u(), 2);
        b_mode = 0;
        t_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tuser_in_splitter.md
Name: tuser_in_splitter

Overview:
- Parametrised successor of the tuser ingress FSM.
- Splits an incoming AXI4-Stream (data + per-beat tuser) into two outputs:
  - a data-only AXIS stream, with full backpressure and full throughput;
  - a per-packet tuple stream carrying the tuser sampled on each packet's first beat.
- The tuple output is buffered in a TUPLE_DEPTH-entry FIFO with its own ready, so the parser/tuple consumer can lag the data path.
- Sits between the MAC-side AXIS ingress and the SDNet packet-processing core.

Parameters:
- DATA_W, 256, AXIS data width in bits; multiple of 8.
- USER_W, 128, tuser and tuple width in bits.
- TUPLE_DEPTH, 4, tuple FIFO entries; power of 2, at least 2.
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- tin_aclk  in  1  clock.
- tin_arst  in  1  reset; asynchronous, active-low.
- tin_avalid  in  1  input beat valid.
- tin_aready  out  1  input beat ready.
- tin_adata  in  DATA_W  input data.
- tin_akeep  in  DATA_W/8  input byte enables.
- tin_atlast  in  1  input end of packet.
- tin_atuser  in  USER_W  input metadata; meaningful on the first beat only.
- tin_bvalid  out  1  output beat valid.
- tin_bready  in  1  output beat ready.
- tin_bdata  out  DATA_W  output data.
- tin_bkeep  out  DATA_W/8  output byte enables.
- tin_btlast  out  1  output end of packet.
- tin_valid  out  1  tuple valid.
- tin_ready  in  1  tuple ready.
- tin_data  out  USER_W  tuple (tuser of the packet's first beat).
- dbg_state  out  2  FSM state.

Behaviour:
- Reset (tin_arst=0, asynchronous), applied immediately:
  - all outputs driven 0, including tin_aready;
  - FSM in SOP; skid buffer and tuple FIFO empty; counters 0.
- Reset release: tin_aready rises on the first clock edge after release.
- Reset mid-packet discards the partial packet and any queued tuples. The first beat after reset is treated as a SOP.
- FSM states (dbg_state):
  - 2'b00 SOP: expecting the first beat of a packet.
  - 2'b01 BODY: inside a packet.
  - 2'b10 and 2'b11 unused; decode to SOP.
- Accept condition: a beat is accepted when tin_avalid & tin_aready.
- Transitions:
  - SOP, accepted beat with tlast=0: go to BODY.
  - SOP, accepted beat with tlast=1 (single-beat packet): stay in SOP.
  - BODY, accepted beat with tlast=1: go to SOP.
  - Any other accepted beat: stay in the current state.
- tin_aready = !skid_full && !(state==SOP && tuple_full). It is derived from registered state only and has no combinational path from tin_bready or tin_ready.
- Tuple capture:
  - On an accepted SOP beat, tin_atuser is pushed into the tuple FIFO.
  - tuser on non-SOP beats is ignored.
- Data path:
  - Two-entry output register plus skid buffer.
  - Sustains 1 beat/cycle when tin_bready=1.
  - Latency is 1 cycle from acceptance to tin_bvalid.
  - tdata, tkeep and tlast pass through unmodified and in order.
  - Output obeys AXIS: once tin_bvalid=1, the beat is held stable until tin_bready=1.
- Tuple path:
  - FIFO with a registered head.
  - Tuple is visible on tin_valid/tin_data 1 cycle after the SOP beat is accepted.
  - Popped when tin_valid & tin_ready.
  - tin_data is held stable while tin_valid=1 and tin_ready=0.
- Tuple FIFO full:
  - Stalls only at a SOP: a packet whose SOP has already been accepted always completes.
  - Simultaneous pop while full frees the slot on the following cycle (the full flag is registered); no push occurs in the same cycle.
- Simultaneous push and pop when not full: the occupancy count is unchanged.
- Empty tuple FIFO: tin_valid=0; tin_data holds its last value.
- Ordering: the tuple and data streams are independently backpressured. The Nth tuple always corresponds to the Nth packet on tin_b.
- Zero-keep beats are forwarded as-is; no filtering.

Optional Feature:
- Macro: TIN_STATS_EN.
- When defined, adds three outputs:
  - stat_pkts (CNT_W): increments per accepted tlast beat.
  - stat_beats (CNT_W): increments per accepted beat.
  - stat_sop_stall (CNT_W): increments each cycle with state==SOP, tin_avalid=1 and tuple_full=1.
- Counters wrap modulo 2^CNT_W and reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then 3 back-to-back 4-beat packets with tin_bready=tin_ready=1 -> 12 beats on tin_b with no bubbles; tuples A, B, C each appear 1 cycle after their SOP; tin_btlast on beats 4, 8, 12.
- Single-beat packets (tlast=1 on every beat), 8 in a row -> FSM stays in SOP; 8 tuples emitted in order; 8 data beats emitted.
- tin_ready=0, TUPLE_DEPTH=4, 6 packets of 2 beats -> after 4 SOPs, tin_aready=0 at the 5th SOP while the 4th packet completes fully; raise tin_ready -> the 5th SOP is accepted on the cycle after the first pop.
- tin_bready toggling 1,0,1,0 during a 5-beat packet -> no beat lost or duplicated; tin_bdata is stable while stalled; tin_aready is never high with the skid buffer full.
- Assert tin_arst=0 mid-packet (beat 2 of 4) -> all outputs 0 immediately; after release, the next beat is treated as a SOP and its tuser appears on tin_data.
- With TIN_STATS_EN, 3 packets of 4 beats plus 2 SOP stall cycles -> stat_pkts=3, stat_beats=12, stat_sop_stall=2.
